gray_rd_ptr_ctrl: RTL and testbench
===================================

GRAY_RD_PTR_CTRL -- requirements
Module: gray_rd_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of FIFO depth; pointer width PW = ADDR_WIDTH+1.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port wr_ptr_gray_i  input  PW  write-side Gray pointer, asynchronous to clk_i, at most one bit changes per update.
REQ-005 SHALL have port rd_en_i  input  1  read request.
REQ-006 SHALL have port rd_ack_o  output  1  read accepted this cycle.
REQ-007 SHALL have port rd_addr_o  output  ADDR_WIDTH  RAM read address.
REQ-008 SHALL have port rd_ptr_gray_o  output  PW  registered Gray read pointer for the write domain.
REQ-009 SHALL have port empty_o  output  1  no word available.
REQ-010 SHALL have port fill_cnt_o  output  PW  words available, 0..2^ADDR_WIDTH.
REQ-011 SHALL have port underflow_o  output  1  one-cycle pulse: read requested while empty.
REQ-012 SHALL have port err_o  output  1  sticky: illegal pointer distance.

Function
REQ-013 SHALL pass wr_ptr_gray_i through two flops, sync1 then sync2, with no logic between them.
REQ-014 SHALL convert sync2 to binary wbin by MSB copy then XOR chain: wbin[i] = wbin[i+1] ^ sync2[i].
REQ-015 SHALL drive rd_ack_o combinationally as rd_en_i AND NOT empty_o.
REQ-016 SHALL keep binary read pointer rbin; rbin_next = rbin+1 mod 2^PW when rd_ack_o, else rbin.
REQ-017 SHALL drive rd_addr_o = rbin[ADDR_WIDTH-1:0], current pointer, zero added latency.
REQ-018 SHALL register rd_ptr_gray_o <= rbin_next ^ (rbin_next >> 1), so it is always Gray of rbin.
REQ-019 SHALL register empty_o <= (Gray(rbin_next) == sync2), using sync2 before its own update.
REQ-020 SHALL register fill_cnt_o <= (wbin - rbin_next) mod 2^PW on the same edge as empty_o.
REQ-021 SHALL give a write-pointer change 3 rising edges of latency to empty_o/fill_cnt_o: sync1, sync2, flags.
REQ-022 SHALL leave rbin, rd_ptr_gray_o and fill_cnt_o unaffected by rd_en_i while empty_o=1; rd_ack_o SHALL stay 0.
REQ-023 SHALL register underflow_o <= rd_en_i AND empty_o, a 1-cycle pulse per offending cycle.
REQ-024 SHALL wrap at all-ones: rbin 2^PW-1 goes to 0; fill arithmetic modulo 2^PW.
REQ-025 SHALL, on a read and a write-pointer arrival at sync2 in the same cycle, reflect both on one edge (net fill unchanged).
REQ-026 SHALL set err_o and hold it until reset when the computed distance exceeds 2^ADDR_WIDTH; fill_cnt_o then carries the raw value.

Reset
REQ-027 SHALL, on rst_n_i=0 at a rising edge, set sync1, sync2, rbin, rd_ptr_gray_o, fill_cnt_o, underflow_o and err_o to 0, and empty_o to 1, overriding rd_en_i.
REQ-028 SHALL give reset mid-operation no residual effect; first post-reset state equals power-up state.

Structure
REQ-029 SHALL place PW derivation and a bin-to-Gray function in the shared BIN-GRAY package.
REQ-030 SHALL instantiate GRAY2BIN (DATA_WIDTH=PW) for REQ-014 as its only sub-module.

Verification (ADDR_WIDTH=4)
REQ-031 SHALL check reset: rst_n_i=0 for 2 cycles, wr_ptr_gray_i=5'b00011 -> empty_o=1, fill_cnt_o=0, rd_ptr_gray_o=0, rd_addr_o=0, err_o=0.
REQ-032 SHALL check latency: wr_ptr_gray_i 00000->00001 at edge 0 -> empty_o=0, fill_cnt_o=1 after edge 3; rd_en_i=1 -> rd_ack_o=1, next edge empty_o=1, rd_ptr_gray_o=00001.
REQ-033 SHALL check full and wrap: wr_ptr_gray_i=11000 (bin 16) -> fill_cnt_o=16; 16 acked reads -> rd_ptr_gray_o=11000, empty_o=1; from rbin=31 (gray 10000), one read -> rbin 0, rd_ptr_gray_o=00000.
REQ-034 SHALL check underflow: rd_en_i=1 while empty -> rd_ack_o=0, rd_addr_o unchanged, underflow_o=1 one cycle later for one cycle.
REQ-035 SHALL check simultaneous read and arrival: fill_cnt_o=3, rd_ack_o=1 and sync2 advancing by 1 on the same edge -> fill_cnt_o stays 3.
REQ-036 SHALL check reset mid-operation and error: fill_cnt_o=5, rd_en_i=1, rst_n_i=0 -> REQ-031 state next edge; wr bin 20 vs rbin 0 -> err_o=1, sticky until reset.

Source files
------------

// File: rtl/gray_rd_ptr_ctrl_pkg.sv
// Shared binary/Gray helpers for the FIFO read-pointer controller.
// Contains pointer-width derivation and a wide bin-to-Gray function; callers cast the result down.
package gray_rd_ptr_ctrl_pkg;

   localparam int unsigned GRAY_FN_W = 32;

   function automatic int unsigned ptr_width(input int unsigned addr_width);
      return addr_width + 32'd1;
   endfunction

   function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_rd_ptr_ctrl_gray2bin.sv
// Gray-to-binary converter: bit i is the XOR of all Gray bits from the MSB down to i.
// Computing each bit as a reduction avoids a self-referencing vector.
module gray_rd_ptr_ctrl_gray2bin #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0] gray_i,
   output logic [DATA_WIDTH-1:0] bin_o
);

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[DATA_WIDTH-1:i];
   end

endmodule

// File: rtl/gray_rd_ptr_ctrl.sv
// Read side of an async FIFO: synchronises the write Gray pointer, keeps the read pointer,
// and produces empty, fill count, underflow pulse and a sticky pointer-distance error.
module gray_rd_ptr_ctrl
   import gray_rd_ptr_ctrl_pkg::*;
#(
   parameter  int ADDR_WIDTH = 4,
   localparam int PW         = int'(ptr_width(ADDR_WIDTH))
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [PW-1:0]         wr_ptr_gray_i,
   input  logic                  rd_en_i,
   output logic                  rd_ack_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic [PW-1:0]         rd_ptr_gray_o,
   output logic                  empty_o,
   output logic [PW-1:0]         fill_cnt_o,
   output logic                  underflow_o,
   output logic                  err_o
);

   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [PW-1:0] sync1_q;
   logic [PW-1:0] sync2_q;
   logic [PW-1:0] rbin_q;
   logic [PW-1:0] rbin_d;
   logic [PW-1:0] rd_ptr_gray_q;
   logic [PW-1:0] gray_next_s;
   logic [PW-1:0] wbin_s;
   logic [PW-1:0] fill_q;
   logic [PW-1:0] fill_d;
   logic          empty_q;
   logic          empty_d;
   logic          underflow_q;
   logic          err_q;
   logic          err_d;
   logic          rd_ack_s;

   gray_rd_ptr_ctrl_gray2bin #(
      .DATA_WIDTH(PW)
   ) u_gray2bin (
      .gray_i(sync2_q),
      .bin_o (wbin_s)
   );

   assign rd_ack_s = rd_en_i & ~empty_q;

   // Next read pointer and the flag values it implies against the synchronised write pointer.
   always_comb begin
      rbin_d      = rbin_q;
      gray_next_s = '0;
      fill_d      = '0;
      empty_d     = 1'b1;
      err_d       = err_q;
      if (rd_ack_s) begin
         rbin_d = rbin_q + PTR_ONE;
      end else begin
         rbin_d = rbin_q;
      end
      gray_next_s = PW'(bin2gray(GRAY_FN_W'(rbin_d)));
      empty_d     = (gray_next_s == sync2_q);
      fill_d      = wbin_s - rbin_d;
      if (fill_d > DEPTH) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Two-flop synchroniser for the write-domain pointer; nothing sits between the stages.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= wr_ptr_gray_i;
         sync2_q <= sync1_q;
      end
   end

   // Read pointer, its Gray image and the status flags, all updated on the same edge.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rbin_q        <= '0;
         rd_ptr_gray_q <= '0;
         empty_q       <= 1'b1;
         fill_q        <= '0;
         underflow_q   <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         rbin_q        <= rbin_d;
         rd_ptr_gray_q <= gray_next_s;
         empty_q       <= empty_d;
         fill_q        <= fill_d;
         underflow_q   <= rd_en_i & empty_q;
         err_q         <= err_d;
      end
   end

   assign rd_ack_o      = rd_ack_s;
   assign rd_addr_o     = rbin_q[ADDR_WIDTH-1:0];
   assign rd_ptr_gray_o = rd_ptr_gray_q;
   assign empty_o       = empty_q;
   assign fill_cnt_o    = fill_q;
   assign underflow_o   = underflow_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_gray_rd_ptr_ctrl.sv
// Scoreboard bench for gray_rd_ptr_ctrl (ADDR_WIDTH=4): a count-based reference model pushes
// expected outputs each cycle and a negedge monitor pops and compares them.
module tb_gray_rd_ptr_ctrl;

   localparam int AW    = 4;
   localparam int PW    = 5;
   localparam int MOD   = 32;
   localparam int DEPTH = 16;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic [PW-1:0] wr_ptr_gray_i;
   logic          rd_en_i;
   logic          rd_ack_o;
   logic [AW-1:0] rd_addr_o;
   logic [PW-1:0] rd_ptr_gray_o;
   logic          empty_o;
   logic [PW-1:0] fill_cnt_o;
   logic          underflow_o;
   logic          err_o;

   always #5 clk_i = ~clk_i;

   gray_rd_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .wr_ptr_gray_i(wr_ptr_gray_i),
      .rd_en_i      (rd_en_i),
      .rd_ack_o     (rd_ack_o),
      .rd_addr_o    (rd_addr_o),
      .rd_ptr_gray_o(rd_ptr_gray_o),
      .empty_o      (empty_o),
      .fill_cnt_o   (fill_cnt_o),
      .underflow_o  (underflow_o),
      .err_o        (err_o)
   );

   typedef struct {
      int ack;
      int addr;
      int gray;
      int empty;
      int fill;
      int under;
      int err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // reference model state: reads and writes as plain counts modulo 2^PW
   int   rcount = 0;
   int   m_fill = 0;
   bit   m_empty = 1'b1;
   bit   m_under = 1'b0;
   bit   m_err = 1'b0;
   int   seen_q[$];
   bit   cur_rst;
   bit   cur_ren;
   int   cur_w;
   int   wcount;

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
      end
   endtask

   // Advance the model across one rising edge using the inputs that were on the pins.
   task automatic model_edge();
      bit ack;
      int seen;
      if (!cur_rst) begin
         rcount  = 0;
         m_empty = 1'b1;
         m_fill  = 0;
         m_under = 1'b0;
         m_err   = 1'b0;
         seen_q  = '{0, 0};
      end else begin
         ack     = cur_ren && !m_empty;
         m_under = cur_ren && m_empty;
         if (ack) rcount = (rcount + 1) % MOD;
         seen    = seen_q[0];
         m_fill  = (seen - rcount + MOD) % MOD;
         m_empty = (seen == rcount);
         if (m_fill > DEPTH) m_err = 1'b1;
         void'(seen_q.pop_front());
         seen_q.push_back(cur_w);
      end
   endtask

   task automatic tick(input bit rst, input bit ren, input int w);
      exp_t e;
      @(posedge clk_i);
      #1;
      model_edge();
      cur_rst       = rst;
      cur_ren       = ren;
      cur_w         = w % MOD;
      rst_n_i       = rst;
      rd_en_i       = ren;
      wr_ptr_gray_i = to_gray(cur_w);
      e.ack   = (ren && !m_empty) ? 1 : 0;
      e.addr  = rcount % DEPTH;
      e.gray  = int'(to_gray(rcount));
      e.empty = m_empty;
      e.fill  = m_fill;
      e.under = m_under;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_empty"}, empty_o, 1);
      check({tag, "_fill"}, fill_cnt_o, 0);
      check({tag, "_gray"}, rd_ptr_gray_o, 0);
      check({tag, "_addr"}, rd_addr_o, 0);
      check({tag, "_err"}, err_o, 0);
   endtask

   always @(negedge clk_i) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("sb_ack", rd_ack_o, mon_e.ack);
         check("sb_addr", rd_addr_o, mon_e.addr);
         check("sb_gray", rd_ptr_gray_o, mon_e.gray);
         check("sb_empty", empty_o, mon_e.empty);
         check("sb_fill", fill_cnt_o, mon_e.fill);
         check("sb_underflow", underflow_o, mon_e.under);
         check("sb_err", err_o, mon_e.err);
      end
   end

   initial begin
      seen_q        = '{0, 0};
      cur_rst       = 1'b0;
      cur_ren       = 1'b0;
      cur_w         = 2;
      rst_n_i       = 1'b0;
      rd_en_i       = 1'b0;
      wr_ptr_gray_i = to_gray(2);

      // reset with a non-zero write pointer on the input
      tick(1'b0, 1'b0, 2);
      tick(1'b0, 1'b0, 2);
      check_reset_state("rst");
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 2);
      check("rst_release_fill", fill_cnt_o, 2);

      // three-edge latency of a single write increment, then one read
      tick(1'b0, 1'b0, 0);
      tick(1'b0, 1'b0, 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, 1);
      tick(1'b1, 1'b0, 1);
      check("lat_e1_empty", empty_o, 1);
      tick(1'b1, 1'b0, 1);
      check("lat_e2_empty", empty_o, 1);
      tick(1'b1, 1'b0, 1);
      check("lat_e3_empty", empty_o, 0);
      check("lat_e3_fill", fill_cnt_o, 1);
      tick(1'b1, 1'b1, 1);
      #1;
      check("lat_ack", rd_ack_o, 1);
      tick(1'b1, 1'b0, 1);
      check("lat_rd_empty", empty_o, 1);
      check("lat_rd_gray", rd_ptr_gray_o, 5'b00001);

      // full at 16 words, drain, then wrap the read pointer through all-ones
      tick(1'b0, 1'b0, 0);
      tick(1'b0, 1'b0, 0);
      tick(1'b1, 1'b0, 0);
      tick(1'b1, 1'b0, 16);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16);
      check("full_fill", fill_cnt_o, 16);
      check("full_err", err_o, 0);
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, 1'b1, 16);
         #1;
         check("full_rd_ack", rd_ack_o, 1);
      end
      tick(1'b1, 1'b0, 16);
      check("drain_gray", rd_ptr_gray_o, 5'b11000);
      check("drain_empty", empty_o, 1);
      tick(1'b1, 1'b0, 32);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32);
      for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 32);
      tick(1'b1, 1'b0, 32);
      check("wrap31_gray", rd_ptr_gray_o, 5'b10000);
      check("wrap31_fill", fill_cnt_o, 1);
      tick(1'b1, 1'b1, 32);
      tick(1'b1, 1'b0, 32);
      check("wrap0_gray", rd_ptr_gray_o, 5'b00000);
      check("wrap0_addr", rd_addr_o, 0);
      check("wrap0_empty", empty_o, 1);

      // read while empty
      tick(1'b1, 1'b1, 0);
      #1;
      check("under_ack", rd_ack_o, 0);
      check("under_addr", rd_addr_o, 0);
      tick(1'b1, 1'b0, 0);
      check("under_pulse", underflow_o, 1);
      check("under_addr_hold", rd_addr_o, 0);
      tick(1'b1, 1'b0, 0);
      check("under_clear", underflow_o, 0);

      // read and pointer arrival on the same edge
      tick(1'b1, 1'b0, 3);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 3);
      check("simul_pre_fill", fill_cnt_o, 3);
      tick(1'b1, 1'b0, 4);
      tick(1'b1, 1'b0, 4);
      tick(1'b1, 1'b1, 4);
      #1;
      check("simul_ack", rd_ack_o, 1);
      tick(1'b1, 1'b0, 4);
      check("simul_fill", fill_cnt_o, 3);
      check("simul_addr", rd_addr_o, 1);

      // reset mid-operation, then sticky distance error
      tick(1'b1, 1'b0, 6);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 6);
      check("mid_fill", fill_cnt_o, 5);
      tick(1'b0, 1'b1, 6);
      tick(1'b1, 1'b0, 20);
      check_reset_state("mid_rst");
      check("mid_rst_under", underflow_o, 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 20);
      check("err_set", err_o, 1);
      check("err_raw_fill", fill_cnt_o, 20);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 0);
      check("err_sticky", err_o, 1);
      tick(1'b0, 1'b0, 0);
      tick(1'b1, 1'b0, 0);
      check("err_cleared", err_o, 0);

      // randomized traffic with occasional resets
      wcount = 0;
      for (int i = 0; i < 1500; i++) begin
         bit rst;
         bit ren;
         rst = ($urandom_range(0, 299) != 0);
         ren = ($urandom_range(0, 1) != 0);
         if (!rst) begin
            wcount = 0;
         end else if ($urandom_range(0, 2) != 0 && ((wcount - rcount + MOD) % MOD) < DEPTH) begin
            wcount = (wcount + 1) % MOD;
         end
         tick(rst, ren, wcount);
      end
      tick(1'b1, 1'b0, wcount);
      @(negedge clk_i);
      #1;
      check("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
